// File: rtl/ce_pkg.sv
// ce_pkg: shared types and constants for the ce_ls scaler: beat sideband, saturation limits, shift clamp.
package ce_pkg;

    localparam int W_FFTPTS = 12;

    // Everything that must stay aligned with a data beat through the pipeline.
    typedef struct packed {
        logic                sop;
        logic                eop;
        logic [1:0]          error;
        logic [W_FFTPTS-1:0] fftpts;
    } beat_sb_t;

    function automatic int sat_hi(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int w);
        return -(1 << (w - 1));
    endfunction

    function automatic int shift_max(input int w_in, input int w_out);
        return w_in - w_out;
    endfunction

endpackage

// File: rtl/ce_rnd_sat.sv
// ce_rnd_sat: one sample component; S1 rounds half-up and shifts right by k, S2 saturates to W_OUT bits.
module ce_rnd_sat
    import ce_pkg::*;
#(
    parameter int W_IN    = 36,
    parameter int W_OUT   = 16,
    parameter int W_SHIFT = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld1,
    input  logic                     ld2,
    input  logic [W_SHIFT-1:0]       k,
    input  logic signed [W_IN-1:0]   x,
    output logic signed [W_OUT-1:0]  y,
    output logic                     sat
);
    localparam logic signed [W_IN:0] HI = (W_IN + 1)'(sat_hi(W_OUT));
    localparam logic signed [W_IN:0] LO = (W_IN + 1)'(sat_lo(W_OUT));

    logic signed [W_IN:0] half, sum, r, r1;
    logic over, under;

    // One extra bit keeps the rounding carry of a full-scale input from wrapping.
    always_comb begin
        half  = k == '0 ? '0 : (W_IN + 1)'(1) << (k - 1'b1);
        sum   = {x[W_IN-1], x} + half;
        r     = sum >>> k;
        over  = r1 > HI;
        under = r1 < LO;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1  <= '0;
            y   <= '0;
            sat <= 1'b0;
        end else begin
            if (ld1) r1 <= r;
            if (ld2) begin
                y   <= over ? HI[W_OUT-1:0] : under ? LO[W_OUT-1:0] : r1[W_OUT-1:0];
                sat <= over | under;
            end
        end
    end

endmodule

// File: rtl/ce_ls_scale_sat.sv
// ce_ls_scale_sat: 2-stage complex scaler (shift + half-up round, then saturate) with valid/ready flow.
// Define CE_LS_SAT_CNT_EN to build the per-frame saturation counter on sat_cnt / sat_cnt_valid.
module ce_ls_scale_sat
    import ce_pkg::*;
#(
    parameter int W_IN      = 36,
    parameter int W_OUT     = 16,
    parameter int W_SHIFT   = 6,
    parameter int SHIFT_DEF = 16,
    parameter int W_CNT     = 12
) (
    input  logic                     clk,
    input  logic                     rst_n_sync,
    input  logic                     sink_valid,
    output logic                     sink_ready,
    input  logic                     sink_sop,
    input  logic                     sink_eop,
    input  logic [1:0]               sink_error,
    input  logic signed [W_IN-1:0]   sink_real,
    input  logic signed [W_IN-1:0]   sink_imag,
    input  logic [11:0]              fftpts_in,
    input  logic [W_SHIFT-1:0]       shift_sel,
    output logic                     source_valid,
    input  logic                     source_ready,
    output logic                     source_sop,
    output logic                     source_eop,
    output logic [1:0]               source_error,
    output logic signed [W_OUT-1:0]  source_real,
    output logic signed [W_OUT-1:0]  source_imag,
    output logic [11:0]              fftpts_out,
    output logic [W_CNT-1:0]         sat_cnt,
    output logic                     sat_cnt_valid
);
    localparam int SMAX = shift_max(W_IN, W_OUT);

    logic               s1_v, s2_v, s1_adv, s2_adv, accept, sop_acc, sat_re, sat_im;
    logic [W_SHIFT-1:0] k_reg, k_use;
    logic [11:0]        fft_reg;
    beat_sb_t           sb_in, s1_sb, s2_sb;

    // A stage advances when it is empty or its successor advances; the sop beat uses its own k and fftpts.
    always_comb begin
        s2_adv       = !s2_v || source_ready;
        s1_adv       = !s1_v || s2_adv;
        sink_ready   = s1_adv;
        accept       = sink_valid && s1_adv;
        sop_acc      = accept && sink_sop;
        k_use        = !sop_acc ? k_reg : int'(shift_sel) > SMAX ? W_SHIFT'(SMAX) : shift_sel;
        sb_in        = '{sop: sink_sop, eop: sink_eop, error: sink_error,
                         fftpts: sop_acc ? fftpts_in : fft_reg};
        source_valid = s2_v;
        source_sop   = s2_sb.sop;
        source_eop   = s2_sb.eop;
        source_error = s2_sb.error;
        fftpts_out   = s2_sb.fftpts;
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s1_sb   <= '0;
            s2_sb   <= '0;
            k_reg   <= W_SHIFT'(SHIFT_DEF);
            fft_reg <= '0;
        end else begin
            if (s1_adv) s1_v <= sink_valid;
            if (accept) begin
                s1_sb   <= sb_in;
                k_reg   <= k_use;
                fft_reg <= sb_in.fftpts;
            end
            if (s2_adv) s2_v <= s1_v;
            if (s2_adv && s1_v) s2_sb <= s1_sb;
        end
    end

    ce_rnd_sat #(.W_IN(W_IN), .W_OUT(W_OUT), .W_SHIFT(W_SHIFT)) u_re (
        .clk(clk), .rst_n(rst_n_sync), .ld1(accept), .ld2(s2_adv && s1_v),
        .k(k_use), .x(sink_real), .y(source_real), .sat(sat_re)
    );

    ce_rnd_sat #(.W_IN(W_IN), .W_OUT(W_OUT), .W_SHIFT(W_SHIFT)) u_im (
        .clk(clk), .rst_n(rst_n_sync), .ld1(accept), .ld2(s2_adv && s1_v),
        .k(k_use), .x(sink_imag), .y(source_imag), .sat(sat_im)
    );

`ifdef CE_LS_SAT_CNT_EN
    logic             xfer;
    logic [W_CNT-1:0] cnt, total;
    logic [W_CNT:0]   sum;

    // Counting happens on the output transfer; a sop restarts the frame count at that beat.
    always_comb begin
        xfer  = s2_v && source_ready;
        sum   = (s2_sb.sop ? '0 : {1'b0, cnt}) + (W_CNT + 1)'(sat_re) + (W_CNT + 1)'(sat_im);
        total = sum[W_CNT] ? '1 : sum[W_CNT-1:0];
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            cnt           <= '0;
            sat_cnt       <= '0;
            sat_cnt_valid <= 1'b0;
        end else begin
            sat_cnt_valid <= xfer && s2_sb.eop;
            if (xfer) begin
                cnt <= s2_sb.eop ? '0 : total;
                if (s2_sb.eop) sat_cnt <= total;
            end
        end
    end
`else
    logic unused_sat;

    always_comb begin
        unused_sat    = sat_re | sat_im;
        sat_cnt       = '0;
        sat_cnt_valid = 1'b0;
    end
`endif

endmodule

// File: tb/tb_ce_ls_scale_sat.sv
// tb_ce_ls_scale_sat: directed vectors for rounding, saturation, back-pressure, shift latching, reset and framing.
`timescale 1ns/1ps
module tb_ce_ls_scale_sat;

`ifdef CE_LS_SAT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        sop;
        logic        eop;
        logic [1:0]  err;
        logic [11:0] fft;
    } obeat_t;

    logic               clk = 1'b0, rst_n_sync = 1'b1;
    logic               sink_valid = 1'b0, sink_ready, sink_sop = 1'b0, sink_eop = 1'b0;
    logic [1:0]         sink_error = '0;
    logic signed [35:0] sink_real = '0, sink_imag = '0;
    logic [11:0]        fftpts_in = '0;
    logic [5:0]         shift_sel = 6'd16;
    logic               source_valid, source_ready = 1'b1, source_sop, source_eop;
    logic [1:0]         source_error;
    logic signed [15:0] source_real, source_imag;
    logic [11:0]        fftpts_out, sat_cnt;
    logic               sat_cnt_valid;

    int          errors = 0, checks = 0;
    obeat_t      out_q[$];
    logic [11:0] sat_q[$];

    ce_ls_scale_sat dut (
        .clk(clk), .rst_n_sync(rst_n_sync),
        .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_error(sink_error), .sink_real(sink_real), .sink_imag(sink_imag),
        .fftpts_in(fftpts_in), .shift_sel(shift_sel),
        .source_valid(source_valid), .source_ready(source_ready), .source_sop(source_sop),
        .source_eop(source_eop), .source_error(source_error), .source_real(source_real),
        .source_imag(source_imag), .fftpts_out(fftpts_out), .sat_cnt(sat_cnt), .sat_cnt_valid(sat_cnt_valid)
    );

    always #5 clk = ~clk;

    function automatic obeat_t mk(input logic [15:0] re, im, input logic sop, eop,
                                  input logic [1:0] err, input logic [11:0] fft);
        mk = '{re: re, im: im, sop: sop, eop: eop, err: err, fft: fft};
    endfunction

    always @(negedge clk) begin
        if (rst_n_sync) begin
            if (source_valid && source_ready)
                out_q.push_back(mk(source_real, source_imag, source_sop, source_eop, source_error, fftpts_out));
            if (sat_cnt_valid) sat_q.push_back(sat_cnt);
        end
    end

    task automatic send(input logic [35:0] re, im, input logic sop, eop, input logic [5:0] sh,
                        input logic [1:0] err, input logic [11:0] fft);
        sink_valid = 1'b1; sink_real = re; sink_imag = im; sink_sop = sop; sink_eop = eop;
        shift_sel = sh; sink_error = err; fftpts_in = fft;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (sink_ready) begin
                @(posedge clk); #1;
                sink_valid = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL send_timeout sink_ready got 0 want 1 within 100 cycles");
        sink_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n_sync = 1'b0;
        #10;
        checks++;
        if ({source_valid, source_sop, source_eop, sat_cnt_valid} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {source_valid, source_sop, source_eop, sat_cnt_valid});
        end
        checks++;
        if ({source_real, source_imag, source_error, fftpts_out, sat_cnt} !== '0) begin
            errors++; $display("FAIL reset_data got %h want 0", {source_real, source_imag, source_error, fftpts_out, sat_cnt});
        end
        checks++;
        if (sink_ready !== 1'b1) begin
            errors++; $display("FAIL reset_sink_ready got %b want 1", sink_ready);
        end
        @(negedge clk) rst_n_sync = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency_single();
        out_q.delete(); sat_q.delete();
        send(36'd98304, -36'sd98304, 1'b1, 1'b1, 6'd16, 2'b01, 12'h080);
        checks++;
        if (source_valid !== 1'b0) begin
            errors++; $display("FAIL lat_early source_valid got %b want 0", source_valid);
        end
        @(posedge clk); #1;
        checks++;
        if ({source_valid, source_real, source_imag, source_sop, source_eop, source_error, fftpts_out}
            !== {1'b1, 16'd2, 16'hFFFF, 1'b1, 1'b1, 2'b01, 12'h080}) begin
            errors++;
            $display("FAIL lat_beat got v=%b re=%h im=%h sop=%b eop=%b err=%b fft=%h want v=1 re=0002 im=ffff sop=1 eop=1 err=01 fft=080",
                     source_valid, source_real, source_imag, source_sop, source_eop, source_error, fftpts_out);
        end
        @(posedge clk); #1;
        checks++;
        if ({sat_cnt_valid, sat_cnt} !== {CNT_EN, 12'd0}) begin
            errors++; $display("FAIL single_frame_strobe got v=%b cnt=%0d want v=%b cnt=0", sat_cnt_valid, sat_cnt, CNT_EN);
        end
        drain();
    endtask

    task automatic test_round();
        obeat_t exp [3];
        exp = '{mk(16'd2, 16'd1, 1, 0, 0, 0), mk(16'hFFFF, 16'd0, 0, 0, 0, 0), mk(16'h7FFF, 16'hFFFE, 0, 1, 0, 0)};
        out_q.delete(); sat_q.delete();
        send(36'd98304, 36'd32768, 1'b1, 1'b0, 6'd16, 2'b00, 12'h000);
        send(-36'sd98304, -36'sd32768, 1'b0, 1'b0, 6'd16, 2'b00, 12'h000);
        send(36'h07FFF8000, -36'sd98305, 1'b0, 1'b1, 6'd16, 2'b00, 12'h000);
        drain();
        checks++;
        if (out_q.size() !== 3) begin
            errors++; $display("FAIL round_count got %0d want 3", out_q.size());
        end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp[i]) begin
                errors++; $display("FAIL round_beat%0d got %h want %h", i, out_q[i], exp[i]);
            end
        end
        checks++;
        if (sat_q.size() !== int'(CNT_EN) || sat_cnt !== (CNT_EN ? 12'd1 : 12'd0)) begin
            errors++; $display("FAIL round_satcnt got events=%0d cnt=%0d want events=%0d cnt=%0d",
                               sat_q.size(), sat_cnt, CNT_EN, CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_sat_both();
        out_q.delete(); sat_q.delete();
        send(36'h800000000, 36'h7FFFFFFFF, 1'b1, 1'b1, 6'd16, 2'b10, 12'h040);
        drain();
        checks++;
        if (out_q.size() !== 1 || out_q[0] !== mk(16'h8000, 16'h7FFF, 1, 1, 2'b10, 12'h040)) begin
            errors++; $display("FAIL sat_both got n=%0d beat=%h want n=1 re=8000 im=7fff", out_q.size(), out_q[0]);
        end
        checks++;
        if (sat_q.size() !== int'(CNT_EN) || sat_cnt !== (CNT_EN ? 12'd2 : 12'd0)) begin
            errors++; $display("FAIL sat_both_cnt got events=%0d cnt=%0d want events=%0d cnt=%0d",
                               sat_q.size(), sat_cnt, CNT_EN, CNT_EN ? 2 : 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] held;
        out_q.delete(); sat_q.delete();
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(36'(i + 1) << 16, -(36'(i + 1) << 16), i == 0, i == 7, 6'd16, 2'(i),
                         i == 0 ? 12'h200 : 12'h3F0 + 12'(i));
            end
            begin
                repeat (3) @(posedge clk);
                #1 source_ready = 1'b0;
                @(negedge clk);
                held = {source_real, source_imag};
                checks++;
                if (held !== {16'd2, 16'hFFFE}) begin
                    errors++; $display("FAIL stall_head got %h want 0002fffe", held);
                end
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    checks++;
                    if (sink_ready !== 1'b0) begin
                        errors++; $display("FAIL stall_sink_ready cycle%0d got 1 want 0", c);
                    end
                    checks++;
                    if ({source_valid, source_real, source_imag} !== {1'b1, held}) begin
                        errors++; $display("FAIL stall_hold cycle%0d got %h want %h", c,
                                           {source_valid, source_real, source_imag}, {1'b1, held});
                    end
                end
                @(posedge clk); #1 source_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (out_q.size() !== 8) begin
            errors++; $display("FAIL b2b_count got %0d want 8", out_q.size());
        end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== mk(16'(i + 1), -16'(i + 1), i == 0, i == 7, 2'(i), 12'h200)) begin
                errors++; $display("FAIL b2b_beat%0d got %h want %h", i, out_q[i],
                                   mk(16'(i + 1), -16'(i + 1), i == 0, i == 7, 2'(i), 12'h200));
            end
        end
    endtask

    task automatic test_shift_change();
        logic [15:0] ere [10] = '{16'd4, 16'd4, 16'd4, 16'd1024, 16'hFC00, 16'd4, 16'd2, 16'd5, 16'h7FFF, 16'd9};
        logic [15:0] eim [10] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF, 16'hFFF9, 16'h8000, 16'd0};
        logic [9:0]  esop = 10'b0010101001;
        logic [9:0]  eeop = 10'b0101010100;
        out_q.delete(); sat_q.delete();
        send(36'd262144, 36'd0, 1, 0, 6'd16, 0, 0);
        send(36'd262144, 36'd0, 0, 0, 6'd8, 0, 0);
        send(36'd262144, 36'd0, 0, 1, 6'd8, 0, 0);
        send(36'd262144, 36'd0, 1, 0, 6'd8, 0, 0);
        send(-36'sd262144, 36'd0, 0, 1, 6'd16, 0, 0);
        send(36'd4194304, 36'd0, 1, 0, 6'd40, 0, 0);
        send(36'd1572864, -36'sd1572864, 0, 1, 6'd8, 0, 0);
        send(36'd5, -36'sd7, 1, 0, 6'd0, 0, 0);
        send(36'd40000, -36'sd40000, 0, 1, 6'd16, 0, 0);
        send(36'd9, 36'd0, 0, 0, 6'd20, 0, 0);
        drain();
        checks++;
        if (out_q.size() !== 10) begin
            errors++; $display("FAIL shift_count got %0d want 10", out_q.size());
        end
        for (int i = 0; i < 10 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== mk(ere[i], eim[i], esop[i], eeop[i], 0, 0)) begin
                errors++; $display("FAIL shift_beat%0d got %h want %h", i, out_q[i],
                                   mk(ere[i], eim[i], esop[i], eeop[i], 0, 0));
            end
        end
        checks++;
        if (sat_cnt !== (CNT_EN ? 12'd2 : 12'd0)) begin
            errors++; $display("FAIL shift_satcnt got %0d want %0d", sat_cnt, CNT_EN ? 2 : 0);
        end
    endtask

    task automatic test_reset_midframe();
        obeat_t exp [3];
        exp = '{mk(16'd4, 0, 0, 0, 0, 0), mk(16'd1024, 0, 1, 0, 0, 12'h123), mk(16'h7FFF, 0, 0, 1, 0, 12'h123)};
        out_q.delete(); sat_q.delete();
        for (int i = 0; i < 4; i++) send(36'h7FFFFFFFF, 36'd0, i == 0, 1'b0, 6'd16, 0, 0);
        #2 rst_n_sync = 1'b0;
        #1;
        checks++;
        if ({source_valid, source_sop, source_real, source_imag, sat_cnt_valid, sink_ready} !== {35'd0, 1'b1}) begin
            errors++; $display("FAIL midreset_outputs got v=%b re=%h im=%h want v=0 re=0000 im=0000",
                               source_valid, source_real, source_imag);
        end
        @(negedge clk) rst_n_sync = 1'b1;
        @(posedge clk); #1;
        drain();
        checks++;
        if (sat_q.size() !== 0 || source_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_flush got events=%0d v=%b want events=0 v=0", sat_q.size(), source_valid);
        end
        out_q.delete();
        send(36'd262144, 36'd0, 1'b0, 1'b0, 6'd8, 0, 12'h555);
        send(36'd262144, 36'd0, 1'b1, 1'b0, 6'd8, 0, 12'h123);
        send(36'h040000000, 36'd0, 1'b0, 1'b1, 6'd16, 0, 12'h777);
        drain();
        checks++;
        if (out_q.size() !== 3) begin
            errors++; $display("FAIL postreset_count got %0d want 3", out_q.size());
        end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp[i]) begin
                errors++; $display("FAIL postreset_beat%0d got %h want %h", i, out_q[i], exp[i]);
            end
        end
        checks++;
        if (sat_q.size() !== int'(CNT_EN) || sat_cnt !== (CNT_EN ? 12'd1 : 12'd0)) begin
            errors++; $display("FAIL postreset_satcnt got events=%0d cnt=%0d want events=%0d cnt=%0d",
                               sat_q.size(), sat_cnt, CNT_EN, CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_sop_restart();
        out_q.delete(); sat_q.delete();
        for (int i = 0; i < 3; i++) send(36'h7FFFFFFFF, 36'd0, i == 0, 1'b0, 6'd16, 0, 0);
        send(36'h7FFFFFFFF, 36'd0, 1'b1, 1'b0, 6'd16, 0, 0);
        send(36'd0, 36'h800000000, 1'b0, 1'b0, 6'd16, 0, 0);
        send(36'd65536, 36'd0, 1'b0, 1'b1, 6'd16, 0, 0);
        drain();
        checks++;
        if (out_q.size() !== 6 || out_q[5] !== mk(16'd1, 16'd0, 0, 1, 0, 0)) begin
            errors++; $display("FAIL restart_out got n=%0d last=%h want n=6 last=%h", out_q.size(), out_q[5],
                               mk(16'd1, 16'd0, 0, 1, 0, 0));
        end
        checks++;
        if (sat_q.size() !== int'(CNT_EN) || sat_cnt !== (CNT_EN ? 12'd2 : 12'd0)) begin
            errors++; $display("FAIL restart_satcnt got events=%0d cnt=%0d want events=%0d cnt=%0d",
                               sat_q.size(), sat_cnt, CNT_EN, CNT_EN ? 2 : 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency_single();
        test_round();
        test_sat_both();
        test_back_to_back();
        test_shift_change();
        test_reset_midframe();
        test_sop_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ce_ls_scale_sat.md
CE_LS_SCALE_SAT -- requirements
Module: ce_ls_scale_sat

Interface
REQ-001 SHALL have parameter W_IN, default 36: width of the sink_real and sink_imag inputs (signed).
REQ-002 SHALL have parameter W_OUT, default 16: width of the source_real and source_imag outputs (signed); W_OUT < W_IN.
REQ-003 SHALL have parameter W_SHIFT, default 6: width of shift_sel.
REQ-004 SHALL have parameter SHIFT_DEF, default 16: shift applied after reset until the first accepted sop.
REQ-005 SHALL have parameter W_CNT, default 12: width of sat_cnt.
REQ-006 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port rst_n_sync, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have ports sink_valid/sink_ready/sink_sop/sink_eop, 1 bit each: sink handshake and framing (sink_ready is the output).
REQ-009 SHALL have port sink_error, input, 2 bits: passed through with the beat.
REQ-010 SHALL have ports sink_real/sink_imag, input, W_IN bits each: two's-complement samples.
REQ-011 SHALL have port fftpts_in, input, 12 bits: captured on the accepted sop beat.
REQ-012 SHALL have port shift_sel, input, W_SHIFT bits: right-shift amount, 0..W_IN-W_OUT, sampled on the accepted sop beat.
REQ-013 SHALL have ports source_valid/source_ready/source_sop/source_eop, 1 bit each, plus source_error, 2 bits: source handshake and framing.
REQ-014 SHALL have ports source_real/source_imag, output, W_OUT bits each: the scaled samples.
REQ-015 SHALL have port fftpts_out, output, 12 bits: frame's fftpts_in, travelling with every beat of that frame.
REQ-016 SHALL have ports sat_cnt (output, W_CNT bits) and sat_cnt_valid (output, 1 bit): per-frame saturation count and its 1-cycle strobe.

Function
REQ-017 A beat SHALL transfer only on a cycle where valid and ready are both high, on sink and on source alike.
REQ-018 SHALL use a 2-stage registered pipeline (S1: shift+round, S2: saturate/output); latency from sink accept to source_valid SHALL be 2 cycles with source_ready held high.
REQ-019 sink_ready SHALL equal !(S1 full AND S2 full AND !source_ready); beats SHALL never be dropped, duplicated or reordered under any source_ready pattern.
REQ-020 Output beat registers SHALL hold stable while source_valid=1 and source_ready=0.
REQ-021 The shift k SHALL be latched on the accepted sop beat and applied to every beat up to and including eop; a beat without a prior sop SHALL use the last latched k.
REQ-022 Rounding SHALL be round-half-up: r = (x + 2^(k-1)) >>> k arithmetically, computed at W_IN+1 bits; k=0 SHALL apply no rounding.
REQ-023 Saturation SHALL apply after rounding: r > 2^(W_OUT-1)-1 gives 0x7FFF, r < -2^(W_OUT-1) gives 0x8000 (W_OUT=16); a rounding carry into overflow SHALL saturate, never wrap.
REQ-024 A shift_sel value > W_IN-W_OUT SHALL be clamped to W_IN-W_OUT.
REQ-025 sop, eop, error and fftpts SHALL travel aligned with their data beat through both stages.
REQ-026 The saturation counter SHALL add 0, 1 or 2 per output beat (real and imag counted separately) and SHALL stick at 2^W_CNT-1.
REQ-027 On the output eop transfer, sat_cnt SHALL take the final frame count (that beat included) and sat_cnt_valid SHALL pulse for 1 cycle; the counter SHALL clear for the next frame.
REQ-028 A sop arriving without a prior eop SHALL restart the count at that sop beat, with no sat_cnt_valid pulse for the abandoned frame.
REQ-029 A single-beat frame (sop=eop=1) SHALL produce sat_cnt_valid on that beat.

Reset
REQ-030 On rst_n_sync low, asynchronously: source_valid, source_sop, source_eop, sat_cnt_valid = 0; source_real, source_imag, source_error, sat_cnt, fftpts_out = 0; both stages empty; k = SHIFT_DEF.
REQ-031 Reset mid-frame SHALL discard all in-flight beats; the first beat after reset SHALL be treated as mid-frame until a sop arrives.

Configuration
REQ-032 Macro CE_LS_SAT_CNT_EN defined: the counter and the sat_cnt/sat_cnt_valid behaviour of REQ-026..029 SHALL be present.
REQ-033 CE_LS_SAT_CNT_EN undefined: sat_cnt and sat_cnt_valid SHALL be tied to 0 with no counter logic; all other behaviour SHALL be unchanged.

Structure
REQ-034 Package ce_pkg SHALL hold the saturation-limit constants function, the shift clamp constant and the beat sideband struct (sop, eop, error, fftpts).
REQ-035 The per-component round+saturate datapath SHALL be sub-module ce_rnd_sat, instantiated twice (real, imag).

Verification
REQ-036 W_IN=36, W_OUT=16, k=16: real=98304 (1.5) -> 2; real=-98304 -> -1; real=0x7FFF8000 -> 0x7FFF with sat count +1.
REQ-037 real=0x800000000 and imag=0x7FFFFFFFF on one beat -> 0x8000 and 0x7FFF, sat_cnt=2 at eop.
REQ-038 8-beat frame, source_ready low cycles 3..7 -> all 8 beats out in order, sink_ready low while both stages full, data stable while stalled.
REQ-039 shift_sel changes from 16 to 8 mid-frame -> that frame uses 16; the next sop frame uses 8; shift_sel=40 -> clamped to 20.
REQ-040 rst_n_sync pulsed low at beat 4 of an 8-beat frame -> outputs 0 immediately, no sat_cnt_valid, next sop frame correct.
REQ-041 sop at beat 3 of an unterminated frame -> count restarts, sat_cnt_valid only at the new frame's eop.
